// File: rtl/uart_host.sv
// uart_host -- bus initiator for a UART's CPU-side register port.
//
// Turns a single-cycle valid/ready request into a timed NCS / NO|NW
// sequence: SETUP_CYCLES of address setup, STROBE_CYCLES of strobe low and
// HOLD_CYCLES of hold, then returns to idle with a one-cycle rsp_valid.
// Read data is captured when the strobe ends and is presented on rsp_rdata
// alongside rsp_valid. NINT is synchronized and inverted onto irq.
//
// Ports
//   clk, reset             rising-edge clock, async active-high reset
//   req_valid/req_ready    request handshake (accepted only in idle)
//   req_write/addr/wdata   request payload, latched at accept
//   rsp_valid, rsp_rdata   completion pulse and read data
//   irq                    synchronized interrupt, active-high
//   ADDR, NCS, NO, NW      registered bus controls to the UART
//   data                   bidirectional UART data bus
//   NINT                   active-low interrupt from the UART
module uart_host #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       irq,
  output logic [1:0] ADDR,
  output logic       NCS,
  output logic       NO,
  output logic       NW,
  inout  wire  [7:0] data,
  input  logic       NINT
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
    $error("uart_host: SETUP_CYCLES must be in 1..15");
  end
  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
    $error("uart_host: STROBE_CYCLES must be in 1..15");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
    $error("uart_host: HOLD_CYCLES must be in 1..15");
  end

  // Phase counter counts down to zero; load value is length-1.
  localparam logic [3:0] S_LD = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] T_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] H_LD = 4'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       accept;
  logic       wr_q;
  logic       oe;
  logic [7:0] dout;
  logic [7:0] rd_cap;
  logic       done;
  logic       strobe_end;
  logic [1:0] nint_sync;

  assign req_ready  = (state == IDLE);
  assign accept     = req_ready && req_valid;
  assign done       = (state == HOLD) && (state_nx == IDLE);
  assign strobe_end = (state == STROBE) && (state_nx == HOLD);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nx = SETUP;
          cnt_nx   = S_LD;
        end
      end
      SETUP: begin
        if (cnt == 4'd0) begin
          state_nx = STROBE;
          cnt_nx   = T_LD;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      STROBE: begin
        if (cnt == 4'd0) begin
          state_nx = HOLD;
          cnt_nx   = H_LD;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (cnt == 4'd0) begin
          state_nx = IDLE;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // Bus outputs are registered from the next state so they change on the
  // same edge as the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      wr_q      <= 1'b0;
      ADDR      <= 2'd0;
      dout      <= 8'd0;
      oe        <= 1'b0;
      NCS       <= 1'b1;
      NO        <= 1'b1;
      NW        <= 1'b1;
      rd_cap    <= 8'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        wr_q <= req_write;
        ADDR <= req_addr;
        dout <= req_wdata;
      end
      NCS <= (state_nx == IDLE);
      // STROBE is never entered straight from IDLE, so wr_q is settled.
      NO  <= !((state_nx == STROBE) && !wr_q);
      NW  <= !((state_nx == STROBE) && wr_q);
      // Write data must be on the bus from the first SETUP cycle, which
      // is before wr_q has been updated, hence the accept bypass.
      oe  <= (state_nx != IDLE) && (accept ? req_write : wr_q);
      // Sampled on the edge that ends the strobe, while NO is still low.
      if (strobe_end && !wr_q) rd_cap <= data;
      rsp_valid <= done;
      if (done && !wr_q) rsp_rdata <= rd_cap;
    end
  end

  assign data = oe ? dout : 8'hzz;

  // Reset to the inactive NINT level so irq comes out of reset low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) nint_sync <= 2'b11;
    else       nint_sync <= {nint_sync[0], NINT};
  end

  assign irq = ~nint_sync[1];

endmodule

// File: tb/tb_uart_host.sv
// Self-checking bench for uart_host. Two instances: u0 with default timing,
// u1 with S=2, T=4, H=3. Each transaction is checked cycle by cycle against
// a timeline computed from the phase lengths: cycle k after accept has NCS
// low for k<=S+T+H, the strobe low for S<k<=S+T, and rsp_valid at k=S+T+H+1.
module tb_uart_host;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]      req_valid, req_write, nint;
  logic [1:0][1:0] req_addr;
  logic [1:0][7:0] req_wdata, uart_val;
  wire  [1:0]      req_ready, rsp_valid, irq, ncs, no, nw;
  wire  [1:0][1:0] addr;
  wire  [1:0][7:0] rsp_rdata;
  tri1  [7:0]      data0, data1;

  // UART model: drives its register value whenever NO is low.
  assign data0 = !no[0] ? uart_val[0] : 8'hzz;
  assign data1 = !no[1] ? uart_val[1] : 8'hzz;

  uart_host u0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .irq(irq[0]),
    .ADDR(addr[0]), .NCS(ncs[0]), .NO(no[0]), .NW(nw[0]),
    .data(data0), .NINT(nint[0])
  );

  uart_host #(.SETUP_CYCLES(2), .STROBE_CYCLES(4), .HOLD_CYCLES(3)) u1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .irq(irq[1]),
    .ADDR(addr[1]), .NCS(ncs[1]), .NO(no[1]), .NW(nw[1]),
    .data(data1), .NINT(nint[1])
  );

  int         n_cmp, n_err;
  int         ph_s [2] = '{1, 2};
  int         ph_t [2] = '{2, 4};
  int         ph_h [2] = '{1, 3};
  logic [7:0] last_rd [2];
  int         d, gap;

  function automatic logic [7:0] dbus(input int i);
    return (i != 0) ? data1 : data0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int i, input string tag);
    chk({tag, "_ready"}, req_ready[i], 1'b1);
    chk({tag, "_rsp_valid"}, rsp_valid[i], 1'b0);
    chk({tag, "_ncs"}, ncs[i], 1'b1);
    chk({tag, "_no"}, no[i], 1'b1);
    chk({tag, "_nw"}, nw[i], 1'b1);
    chk({tag, "_data_z"}, dbus(i), 8'hFF);
  endtask

  // Called at a negedge in an idle cycle; returns at the negedge of the
  // rsp_valid cycle, so an immediate second call is a back-to-back request.
  task automatic txn(input int i, input logic w, input logic [1:0] a,
                     input logic [7:0] wd, input logic [7:0] rv);
    int n, sb, se;
    logic win, strb;
    n  = ph_s[i] + ph_t[i] + ph_h[i];
    sb = ph_s[i];
    se = ph_s[i] + ph_t[i];
    uart_val[i] = rv;
    chk("ready_pre", req_ready[i], 1'b1);
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_addr[i]  = a;
    req_wdata[i] = wd;
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      win  = (k <= n);
      strb = (k > sb) && (k <= se);
      chk("ncs", ncs[i], !win);
      chk("no", no[i], !(strb && !w));
      chk("nw", nw[i], !(strb && w));
      chk("ready", req_ready[i], !win);
      chk("rsp_valid", rsp_valid[i], k == n + 1);
      if (win) chk("addr", addr[i], a);
      chk("data", dbus(i), (w && win) ? wd : (!w && strb) ? rv : 8'hFF);
      if (k == n + 1) begin
        if (!w) last_rd[i] = rv;
        chk("rsp_rdata", rsp_rdata[i], last_rd[i]);
      end
      // Offer junk while busy: it must be ignored.
      if (k <= n) begin
        req_valid[i] = 1'($urandom);
        req_write[i] = 1'($urandom);
        req_addr[i]  = 2'($urandom);
        req_wdata[i] = 8'($urandom);
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    uart_val = '0;
    nint = 2'b11;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;

    // Reset values
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk_idle(i, "rst");
      chk("rst_rdata", rsp_rdata[i], 8'h00);
      chk("rst_irq", irq[i], 1'b0);
      chk("rst_addr", addr[i], 2'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Directed write and read with default timing
    txn(0, 1'b1, 2'd2, 8'hA5, 8'h00);
    @(negedge clk);
    txn(0, 1'b0, 2'd1, 8'h00, 8'h3C);
    @(negedge clk);

    // Back-to-back: second request accepted in the rsp_valid cycle
    txn(0, 1'b1, 2'd0, 8'h11, 8'h00);
    txn(0, 1'b0, 2'd3, 8'h00, 8'hC7);
    @(negedge clk);

    // Reset during STROBE of a write
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 2'd2; req_wdata[0] = 8'h5A;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("pre_rst_nw", nw[0], 1'b0);
    chk("pre_rst_data", data0, 8'h5A);
    #2 reset = 1'b1;
    #1;
    chk_idle(0, "mid_rst");
    chk("mid_rst_addr", addr[0], 2'd0);
    chk("mid_rst_rdata", rsp_rdata[0], 8'h00);
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_rsp", rsp_valid[0], 1'b0);
      chk("post_rst_ncs", ncs[0], 1'b1);
    end
    txn(0, 1'b0, 2'd1, 8'h00, 8'h96);
    @(negedge clk);

    // Custom timing instance: read then write
    txn(1, 1'b0, 2'd2, 8'h00, 8'h4E);
    @(negedge clk);
    txn(1, 1'b1, 2'd1, 8'hE1, 8'h00);
    @(negedge clk);

    // Interrupt synchronizer: two edges of latency, both directions
    for (int i = 0; i < 2; i++) begin
      nint[i] = 1'b0;
      @(negedge clk);
      chk("irq_1edge", irq[i], 1'b0);
      @(negedge clk);
      chk("irq_2edge", irq[i], 1'b1);
      nint[i] = 1'b1;
      @(negedge clk);
      chk("irq_rel_1edge", irq[i], 1'b1);
      @(negedge clk);
      chk("irq_rel_2edge", irq[i], 1'b0);
    end

    // Randomized transactions on either instance with random gaps
    repeat (60) begin
      d   = int'($urandom_range(1, 0));
      gap = int'($urandom_range(2, 0));
      repeat (gap) @(negedge clk);
      if (gap != 0) chk_idle(d, "gap");
      txn(d, 1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom));
    end
    @(negedge clk);
    chk_idle(0, "end0");
    chk_idle(1, "end1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_host.md
# uart_host

Bus initiator that drives the UART's CPU-side register interface (ADDR, NCS, NO, NW, bidirectional data, NINT). Converts a single-cycle valid/ready request from the core into a timed chip-select / strobe sequence with programmable setup, strobe and hold phases. Returns read data and write acknowledges as a one-cycle response, and synchronizes the UART interrupt into the clock domain.

## Interface
- SETUP_CYCLES, 1: cycles with NCS low and address valid before the strobe asserts (legal range 1..15)
- STROBE_CYCLES, 2: cycles NO or NW is held low (legal range 1..15)
- HOLD_CYCLES, 1: cycles with NCS low after the strobe deasserts (legal range 1..15)

- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = register write, 0 = register read
- req_addr  in  2  UART register address
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse: transaction complete
- rsp_rdata  out  8  read data, valid with rsp_valid on reads
- irq  out  1  synchronized interrupt, active-high (inverse of NINT)
- ADDR  out  2  register address to UART
- NCS  out  1  negative chip select
- NO  out  1  negative read enable
- NW  out  1  negative write enable
- data  inout  8  UART data bus
- NINT  in  1  negative interrupt from UART

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD; one 4-bit phase counter; all bus outputs registered.
- IDLE: req_ready=1, NCS=NO=NW=1, data=Z. req_valid&&req_ready at an edge latches req_write/addr/wdata, moves to SETUP, and drops req_ready.
- SETUP (SETUP_CYCLES): NCS=0, ADDR=latched address, strobes high. On writes, data is driven with latched wdata from the first SETUP cycle.
- STROBE (STROBE_CYCLES): NO=0 on reads, NW=0 on writes; the other strobe stays 1.
- HOLD (HOLD_CYCLES): strobes high; NCS=0 and ADDR held. Write data is still driven.
- HOLD exit: return to IDLE. NCS=1, data=Z. rsp_valid=1 for exactly one cycle.
- Reads: data is sampled at the edge ending the last STROBE cycle and held in rsp_rdata until the next read completes. Writes leave rsp_rdata unchanged.
- data is never driven during a read transaction or in IDLE. NO and NW are never low simultaneously.
- irq: NINT passes through a 2-flop synchronizer, then is inverted.
- Requests offered while req_ready=0 are ignored. The requester must hold them.
- Out-of-range parameters are unsupported. The implementation carries an elaboration check.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0x00, irq=0, ADDR=0, NCS=1, NO=1, NW=1, data=Z, state=IDLE.
- Reset is asynchronous. Assertion mid-transaction immediately forces the reset values, with NCS and strobes high and data released. No rsp_valid is issued for the aborted transaction.
- Transaction latency: rsp_valid is high in the cycle after edge E0+S+T+H, where E0 is the accept edge. With defaults this is 4 edges after accept.
- req_ready returns to 1 in the same cycle rsp_valid is 1. A request accepted then starts the next SETUP on the following edge.
- Throughput: NCS is high for at least 1 cycle between transactions. Back-to-back period is S+T+H+1 cycles.
- ADDR and write data are stable for the entire NCS-low window, which guarantees setup and hold around the strobe edges.
- irq follows a NINT change after 2 rising edges.

## Test plan
- Reset: assert reset mid-sim → all outputs at reset values asynchronously, before the next clk edge; data=Z.
- Write, defaults: addr=2, wdata=0xA5 → NCS low for 4 cycles; NW low in cycles 2–3 after accept; data=0xA5 throughout the NCS window; NO stays 1; rsp_valid pulses 4 edges after accept.
- Read, defaults: addr=1, UART model drives 0x3C while NO=0 → rsp_rdata=0x3C with rsp_valid; data never driven by the block; NW stays 1.
- Back-to-back: write 0x11 to addr 0, then read addr 3 with req_valid held high → second accept in the rsp_valid cycle; exactly 1 cycle of NCS=1 between transactions; period 5 cycles.
- Reset during STROBE of a write → NW and NCS return high immediately, data=Z, no rsp_valid; after release the next read completes normally.
- Parameters S=2, T=4, H=3, plus NINT toggle: read latency is 9 edges with NO low for exactly 4 cycles; NINT 1→0 → irq=1 after 2 edges.
